// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port synchronous RAM between a CPU requester
// and a DMA/loader requester, each using a req/ack handshake.
//
// One transaction occupies three cycles: IDLE (arbitrate and latch operands),
// ACCESS (RAM performs the read or write at the closing edge), RESP (ack pulse
// to the owner, with read data passed straight through from the RAM).
//
// Configuration macro:
//   RAM_ARB_RR_EN  defined: round-robin on a tie (the port not served last wins).
//                  undefined: fixed priority, the CPU wins every tie.
//
// Ports:
//   clk, reset_n                       clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata -> cpu_ack   CPU request and one-cycle completion pulse
//   cpu_rdata                          RAM read data, forced to 0 unless cpu_ack
//   dma_req/we/addr/wdata -> dma_ack   DMA request, same semantics as the CPU port
//   dma_rdata                          RAM read data, forced to 0 unless dma_ack
//   ram_addr, ram_data_in, ram_we      RAM inputs (address/data hold outside ACCESS)
//   ram_data_out                       RAM read data, one-cycle latency
//   busy                               high while in ACCESS or RESP
module ram_arbiter #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,

    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_ack,
    output logic [DATA_W-1:0] dma_rdata,

    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data_in,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_data_out,

    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t state;
    logic   owner;        // 0 = CPU, 1 = DMA
    logic   last;         // port served by the most recent completed transaction
    logic   cpu_wins_c;   // CPU takes the grant if arbitration happens this cycle

    // Winner selection; only consulted in IDLE when at least one req is high.
`ifdef RAM_ARB_RR_EN
    always_comb begin
        cpu_wins_c = 1'b0;
        if (cpu_req && dma_req) begin
            cpu_wins_c = last;          // DMA went last, so the CPU gets this turn
        end else begin
            cpu_wins_c = cpu_req;
        end
    end
`else
    always_comb begin
        cpu_wins_c = 1'b0;
        cpu_wins_c = cpu_req;
    end

    // last is kept for observability symmetry with round-robin builds.
    logic unused_last;
    assign unused_last = last;
`endif

    // Transaction sequencer with registered RAM controls and acks.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            owner       <= 1'b0;
            last        <= 1'b1;
            ram_addr    <= '0;
            ram_data_in <= '0;
            ram_we      <= 1'b0;
            cpu_ack     <= 1'b0;
            dma_ack     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cpu_req || dma_req) begin
                        owner <= ~cpu_wins_c;
                        if (cpu_wins_c) begin
                            ram_addr    <= cpu_addr;
                            ram_data_in <= cpu_wdata;
                            ram_we      <= cpu_we;
                        end else begin
                            ram_addr    <= dma_addr;
                            ram_data_in <= dma_wdata;
                            ram_we      <= dma_we;
                        end
                        busy  <= 1'b1;
                        state <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    // RAM commits the operation at this edge; ack lands next cycle.
                    ram_we  <= 1'b0;
                    cpu_ack <= ~owner;
                    dma_ack <= owner;
                    state   <= ST_RESP;
                end
                ST_RESP: begin
                    cpu_ack <= 1'b0;
                    dma_ack <= 1'b0;
                    last    <= owner;
                    busy    <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: begin
                    ram_we  <= 1'b0;
                    cpu_ack <= 1'b0;
                    dma_ack <= 1'b0;
                    busy    <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

    // Read data is passed through only during the owning port's ack cycle.
    assign cpu_rdata = cpu_ack ? ram_data_out : '0;
    assign dma_rdata = dma_ack ? ram_data_out : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: a behavioural RAM, a transaction-level
// reference model that predicts grant order, ack cycles and read data, and a
// monitor that checks DUT outputs against the predicted queues.
module tb_ram_arbiter;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 8;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              cpu_req, cpu_we, dma_req, dma_we;
    logic [ADDR_W-1:0] cpu_addr, dma_addr, ram_addr;
    logic [DATA_W-1:0] cpu_wdata, dma_wdata, cpu_rdata, dma_rdata;
    logic              cpu_ack, dma_ack, ram_we, busy;
    logic [DATA_W-1:0] ram_data_in, ram_data_out;

    always #5 clk = ~clk;

    ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ack(dma_ack), .dma_rdata(dma_rdata),
        .ram_addr(ram_addr), .ram_data_in(ram_data_in), .ram_we(ram_we),
        .ram_data_out(ram_data_out), .busy(busy)
    );

    // Behavioural 4096 x 8 synchronous RAM with one-cycle read latency.
    logic [DATA_W-1:0] ram_mem [0:4095];
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_data_in;
        ram_data_out <= ram_mem[ram_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        int                gap;
    } op_t;

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] rdata;
        int                ack_c;
    } exp_t;

    int checks = 0;
    int errors = 0;

    op_t  cpu_plan[$], dma_plan[$];
    exp_t cpu_q[$], dma_q[$];
    int   cpu_log[$], dma_log[$];

    bit   active [2];
    bit   granted [2];
    bit   has_op [2];
    int   ack_at [2];
    op_t  cur [2];

    int                free_at;
    bit                last_dma;
    logic [DATA_W-1:0] ref_mem [0:4095];

    bit                mon_en = 1'b0;
    logic [ADDR_W-1:0] mon_addr;
    logic [DATA_W-1:0] mon_wd;
    int                we_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    task automatic model_reset();
        cpu_plan.delete(); dma_plan.delete();
        cpu_q.delete();    dma_q.delete();
        for (int p = 0; p < 2; p++) begin
            active[p]  = 1'b0;
            granted[p] = 1'b0;
            has_op[p]  = 1'b0;
            ack_at[p]  = 0;
            cur[p]     = '{we: 1'b0, addr: '0, wdata: '0, gap: 0};
        end
        free_at  = 0;
        last_dma = 1'b1;
        mon_addr = '0;
        mon_wd   = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
    endtask

    // One clock of requester behaviour plus the arbitration prediction for the
    // next edge. A grant at edge g acks in cycle g+1; next arbitration at g+3.
    task automatic step();
        int   k;
        int   w;
        bit   c, d;
        exp_t e;
        @(posedge clk);
        #1;
        k = cyc;
        for (int p = 0; p < 2; p++) begin
            if (granted[p] && ack_at[p] == k - 1) begin
                granted[p] = 1'b0;
                active[p]  = 1'b0;
                has_op[p]  = 1'b0;
            end
            if (!has_op[p]) begin
                if (p == 0 && cpu_plan.size() > 0) begin
                    cur[p] = cpu_plan.pop_front(); has_op[p] = 1'b1;
                end else if (p == 1 && dma_plan.size() > 0) begin
                    cur[p] = dma_plan.pop_front(); has_op[p] = 1'b1;
                end
            end
            if (has_op[p] && !active[p]) begin
                if (cur[p].gap == 0) active[p] = 1'b1;
                else cur[p].gap = cur[p].gap - 1;
            end
        end
        cpu_req = active[0]; cpu_we = cur[0].we; cpu_addr = cur[0].addr; cpu_wdata = cur[0].wdata;
        dma_req = active[1]; dma_we = cur[1].we; dma_addr = cur[1].addr; dma_wdata = cur[1].wdata;

        if (k + 1 >= free_at) begin
            c = active[0] && !granted[0];
            d = active[1] && !granted[1];
            if (c || d) begin
                if (c && d) begin
`ifdef RAM_ARB_RR_EN
                    w = last_dma ? 0 : 1;
`else
                    w = 0;
`endif
                end else begin
                    w = c ? 0 : 1;
                end
                e.we    = cur[w].we;
                e.addr  = cur[w].addr;
                e.wdata = cur[w].wdata;
                e.ack_c = k + 2;
                if (cur[w].we) begin
                    ref_mem[cur[w].addr] = cur[w].wdata;
                    e.rdata = '0;
                end else begin
                    e.rdata = ref_mem[cur[w].addr];
                end
                granted[w] = 1'b1;
                ack_at[w]  = k + 2;
                free_at    = k + 4;
                last_dma   = (w == 1);
                if (w == 0) cpu_q.push_back(e);
                else        dma_q.push_back(e);
            end
        end
    endtask

    task automatic run_until_idle(input int limit);
        for (int i = 0; i < limit; i++) begin
            if (cpu_plan.size() == 0 && dma_plan.size() == 0 && !has_op[0] && !has_op[1]
                && cpu_q.size() == 0 && dma_q.size() == 0) return;
            step();
        end
        fail("idle_timeout");
    endtask

    function automatic op_t mk(input logic we, input int addr, input int wdata, input int gap);
        op_t o;
        o.we    = we;
        o.addr  = ADDR_W'(addr);
        o.wdata = DATA_W'(wdata);
        o.gap   = gap;
        return o;
    endfunction

    // Monitor: compares every cycle against the predicted in-flight transaction.
    always @(negedge clk) begin
        bit exp_busy;
        bit exp_we;
        if (ram_we) we_cnt++;
        if (mon_en) begin
            exp_busy = 1'b0;
            exp_we   = 1'b0;
            if (cpu_q.size() > 0) begin
                if (cpu_q[0].ack_c == cyc || cpu_q[0].ack_c == cyc + 1) exp_busy = 1'b1;
                if (cpu_q[0].ack_c == cyc + 1) begin
                    exp_we = cpu_q[0].we; mon_addr = cpu_q[0].addr; mon_wd = cpu_q[0].wdata;
                end
            end
            if (dma_q.size() > 0) begin
                if (dma_q[0].ack_c == cyc || dma_q[0].ack_c == cyc + 1) exp_busy = 1'b1;
                if (dma_q[0].ack_c == cyc + 1) begin
                    exp_we = dma_q[0].we; mon_addr = dma_q[0].addr; mon_wd = dma_q[0].wdata;
                end
            end
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("ram_we", 32'(ram_we), 32'(exp_we));
            chk("ram_addr", 32'(ram_addr), 32'(mon_addr));
            chk("ram_data_in", 32'(ram_data_in), 32'(mon_wd));
            if (!cpu_ack) chk("cpu_rdata_gated", 32'(cpu_rdata), 32'd0);
            if (!dma_ack) chk("dma_rdata_gated", 32'(dma_rdata), 32'd0);

            if (cpu_ack) begin
                if (cpu_q.size() == 0) fail("cpu_ack_unexpected");
                else begin
                    chk("cpu_ack_cycle", 32'(cyc), 32'(cpu_q[0].ack_c));
                    if (!cpu_q[0].we) chk("cpu_rdata", 32'(cpu_rdata), 32'(cpu_q[0].rdata));
                    cpu_log.push_back(cyc);
                    void'(cpu_q.pop_front());
                end
            end else if (cpu_q.size() > 0 && cpu_q[0].ack_c <= cyc) begin
                fail("cpu_ack_missing");
                void'(cpu_q.pop_front());
            end

            if (dma_ack) begin
                if (dma_q.size() == 0) fail("dma_ack_unexpected");
                else begin
                    chk("dma_ack_cycle", 32'(cyc), 32'(dma_q[0].ack_c));
                    if (!dma_q[0].we) chk("dma_rdata", 32'(dma_rdata), 32'(dma_q[0].rdata));
                    dma_log.push_back(cyc);
                    void'(dma_q.pop_front());
                end
            end else if (dma_q.size() > 0 && dma_q[0].ack_c <= cyc) begin
                fail("dma_ack_missing");
                void'(dma_q.pop_front());
            end
        end
    end

    initial begin
        int we0;
        for (int i = 0; i < 4096; i++) begin
            ram_mem[i] = '0;
            ref_mem[i] = '0;
        end
        reset_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_ram_data_in", 32'(ram_data_in), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
        chk("rst_dma_ack", 32'(dma_ack), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        mon_en  = 1'b1;

        // Simultaneous requests straight out of reset.
        cpu_log.delete(); dma_log.delete();
`ifdef RAM_ARB_RR_EN
        for (int i = 0; i < 4; i++) begin
            cpu_plan.push_back(mk(1'b0, 'h010, 0, 0));
            dma_plan.push_back(mk(1'b1, 'h020, 'h55, 0));
        end
        run_until_idle(200);
        chk("rr_cpu_count", 32'(cpu_log.size()), 32'd4);
        chk("rr_dma_count", 32'(dma_log.size()), 32'd4);
        if (cpu_log.size() == 4 && dma_log.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("rr_dma_after_cpu", 32'(dma_log[i]), 32'(cpu_log[i] + 3));
                if (i < 3) chk("rr_cpu_after_dma", 32'(cpu_log[i + 1]), 32'(dma_log[i] + 3));
            end
        end
`else
        for (int i = 0; i < 4; i++) cpu_plan.push_back(mk(1'b0, 'h010, 0, 0));
        dma_plan.push_back(mk(1'b1, 'h020, 'h55, 0));
        run_until_idle(200);
        chk("fp_cpu_count", 32'(cpu_log.size()), 32'd4);
        chk("fp_dma_count", 32'(dma_log.size()), 32'd1);
        if (cpu_log.size() == 4 && dma_log.size() == 1) begin
            for (int i = 0; i < 3; i++)
                chk("fp_cpu_spacing", 32'(cpu_log[i + 1]), 32'(cpu_log[i] + 3));
            chk("fp_dma_after_cpu", 32'(dma_log[0]), 32'(cpu_log[3] + 3));
        end
`endif
        chk("ram_0x020", 32'(ram_mem[12'h020]), 32'h55);

        // Boot load by DMA, then a CPU read of the middle byte.
        dma_plan.push_back(mk(1'b1, 'h000, 'h10, 0));
        dma_plan.push_back(mk(1'b1, 'h001, 'h14, 0));
        dma_plan.push_back(mk(1'b1, 'h002, 'h04, 0));
        run_until_idle(100);
        cpu_plan.push_back(mk(1'b0, 'h001, 0, 1));
        run_until_idle(100);
        chk("boot_ram_0x001", 32'(ram_mem[12'h001]), 32'h14);

        // Single CPU write then read.
        cpu_log.delete(); dma_log.delete();
        we0 = we_cnt;
        cpu_plan.push_back(mk(1'b1, 'h123, 'hA5, 0));
        cpu_plan.push_back(mk(1'b0, 'h123, 'h00, 1));
        run_until_idle(100);
        chk("single_we_cycles", 32'(we_cnt - we0), 32'd1);
        chk("single_cpu_acks", 32'(cpu_log.size()), 32'd2);
        chk("single_no_dma_ack", 32'(dma_log.size()), 32'd0);

        // DMA read of a preloaded location while the CPU is idle.
        dma_plan.push_back(mk(1'b1, 'h7FF, 'h3C, 0));
        dma_plan.push_back(mk(1'b0, 'h7FF, 'h00, 2));
        run_until_idle(100);

        // Reset while a DMA read is in its ack cycle.
        dma_plan.push_back(mk(1'b0, 'h7FF, 'h00, 0));
        for (int i = 0; i < 20; i++) begin
            if (granted[1] && ack_at[1] == cyc) break;
            step();
        end
        chk("pre_reset_dma_ack", 32'(dma_ack), 32'd1);
        mon_en  = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("async_rst_dma_ack", 32'(dma_ack), 32'd0);
        chk("async_rst_ram_we", 32'(ram_we), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_dma_rdata", 32'(dma_rdata), 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        mon_en  = 1'b1;
        cpu_log.delete(); dma_log.delete();
        cpu_plan.push_back(mk(1'b0, 'h001, 0, 0));
        dma_plan.push_back(mk(1'b0, 'h002, 0, 0));
        run_until_idle(100);
        if (cpu_log.size() == 1 && dma_log.size() == 1)
            chk("post_reset_cpu_first", 32'(dma_log[0]), 32'(cpu_log[0] + 3));
        else
            fail("post_reset_ack_count");

        // Randomised traffic on a small address window to force reuse.
        for (int i = 0; i < 40; i++) begin
            op_t o;
            o.we    = 1'($urandom_range(0, 1));
            o.addr  = ADDR_W'($urandom_range(0, 15));
            o.wdata = DATA_W'($urandom);
            o.gap   = int'($urandom_range(0, 3));
            cpu_plan.push_back(o);
            o.we    = 1'($urandom_range(0, 1));
            o.addr  = ADDR_W'($urandom_range(0, 15));
            o.wdata = DATA_W'($urandom);
            o.gap   = int'($urandom_range(0, 3));
            dma_plan.push_back(o);
        end
        run_until_idle(2000);
        repeat (3) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
